// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I fetch stage.
// Holds XLEN, the canonical NOP word, fetch FSM states and the prefetch entry.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_instruction_fetch_if.sv
// Fetch-stage bus bundle: imem request/response plus the decode handoff.
// master = fetch unit; slave = memory and decode side.
interface rv32i_instruction_fetch_if;
    import rv32i_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_err;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            instr_fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_err,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output instr_fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_err,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  instr_fault
    );

endinterface

// File: rtl/rv32i_fetch_fifo.sv
// In-order prefetch buffer of fetch entries; head is read straight from storage.
// Ports: clk, rst_n, flush, push/wdata, pop, head, count, full, empty.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a full buffer may still take a word when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_instruction_fetch.sv
// RV32I fetch stage: credit-limited imem reads, prefetch buffer, redirect flush.
// Ports: clk, rst_n, fetch_en, redirect_valid, redirect_pc, bus (master side).
module rv32i_instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    rv32i_instruction_fetch_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            hs;
    logic            rv;
    logic            keep;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign redir_pc = redirect_pc & ~32'h3;

    // buffered words plus reads in flight never exceed the buffer size
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};

    assign bus.imem_req = rst_n
                       && (state == FETCH_RUN)
                       && fetch_en
                       && (in_use < (CW+1)'(FIFO_DEPTH))
                       && !redirect_valid;
    assign bus.imem_addr = fetch_pc;

    assign hs   = bus.imem_req && bus.imem_gnt;
    // stray responses with nothing in flight are ignored
    assign rv   = bus.imem_rvalid && (outstanding != '0);
    // stale responses and those arriving with a redirect are discarded
    assign keep = rv && (drop == '0) && !redirect_valid;
    assign pop  = bus.instr_valid && bus.instr_ready;

    always_comb begin
        push_entry.pc    = resp_pc;
        push_entry.fault = bus.imem_err;
        push_entry.data  = bus.imem_err ? RV32I_NOP : bus.imem_rdata;
    end

    always_comb begin
        out_next = outstanding;
        unique case ({hs, rv})
            2'b10:   out_next = outstanding + CW'(1);
            2'b01:   out_next = outstanding - CW'(1);
            default: out_next = outstanding;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                state    <= FETCH_RUN;
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
                // everything still in flight belongs to the old stream
                drop     <= out_next;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (rv && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                unique case (state)
                    FETCH_RUN: begin
                        if (keep && bus.imem_err) begin
                            state <= FETCH_HALT;
                        end
                    end
                    FETCH_HALT: state <= FETCH_HALT;
                    default:    state <= FETCH_HALT;
                endcase
            end
        end
    end

    rv32i_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (keep),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_data  = head.data;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_fault = head.fault;

    a_rvalid_tracked: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.imem_rvalid |-> (outstanding != '0)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        keep |-> !fifo_full
    );

endmodule

// File: tb/tb_rv32i_instruction_fetch.sv
// Directed bench for rv32i_instruction_fetch with an in-order imem model.
// Inputs change on negedge, memory at +1, transfer log at +2, checks at +3.
module tb_rv32i_instruction_fetch;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        hold = 1'b0;
    logic        gnt_en = 1'b1;
    logic        ready = 1'b0;
    logic        err_on = 1'b0;
    logic [31:0] err_addr = 32'h0;

    int n_chk = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    logic [31:0] mq [$];
    logic [31:0] lpc [$];
    logic [31:0] ldat [$];
    logic        lflt [$];

    rv32i_instruction_fetch_if bus ();

    rv32i_instruction_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_gnt    = gnt_en;
    assign bus.instr_ready = ready;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        if (i >= 0 && i < lpc.size()) return lpc[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] dat_at(input int i);
        if (i >= 0 && i < ldat.size()) return ldat[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] flt_at(input int i);
        if (i >= 0 && i < lflt.size()) return {31'b0, lflt[i]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory: in-order responses, one cycle after grant at the earliest
    initial begin
        logic [31:0] a;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.imem_err    = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                bus.imem_rvalid = 1'b0;
                bus.imem_err    = 1'b0;
            end else begin
                if (!hold && mq.size() > 0) begin
                    a = mq.pop_front();
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mdata(a);
                    bus.imem_err    = err_on && (a == err_addr);
                end else begin
                    bus.imem_rvalid = 1'b0;
                    bus.imem_err    = 1'b0;
                end
                if (bus.imem_req && bus.imem_gnt) begin
                    mq.push_back(bus.imem_addr);
                    hs_cnt++;
                end
            end
        end
    end

    // transfer log
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.instr_valid && ready) begin
                lpc.push_back(bus.instr_pc);
                ldat.push_back(bus.instr_data);
                lflt.push_back(bus.instr_fault);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit 200000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int b;
        int hs0;
        int k;
        fetch_en = 1'b1;
        ready    = 1'b1;

        // reset values
        @(negedge clk);
        #3;
        check("rst_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h100);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("rst_data", bus.instr_data, 32'h0);
        check("rst_pc", bus.instr_pc, 32'h0);
        check("rst_fault", {31'b0, bus.instr_fault}, 32'h0);

        // 1: sequential stream from RESET_PC
        @(negedge clk);
        rst_n = 1'b1;
        b = lpc.size();
        #3;
        check("t1_req", {31'b0, bus.imem_req}, 32'h1);
        check("t1_addr", bus.imem_addr, 32'h100);
        check("t1_v0", {31'b0, bus.instr_valid}, 32'h0);
        @(negedge clk);
        #3;
        check("t1_v1", {31'b0, bus.instr_valid}, 32'h0);
        check("t1_rvalid", {31'b0, bus.imem_rvalid}, 32'h1);
        @(negedge clk);
        #3;
        check("t1_v2", {31'b0, bus.instr_valid}, 32'h1);
        check("t1_pc0", bus.instr_pc, 32'h100);
        check("t1_data0", bus.instr_data, 32'h5A5A_0100);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("t1_seq", pc_at(b + i), 32'h100 + 32'(4 * i));
        end

        // 2: decode stalled, buffer fills, then drains in order
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hs0 = hs_cnt;
        b = lpc.size();
        repeat (10) @(negedge clk);
        #3;
        check("t2_hs", 32'(hs_cnt - hs0), 32'd2);
        check("t2_req", {31'b0, bus.imem_req}, 32'h0);
        check("t2_valid", {31'b0, bus.instr_valid}, 32'h1);
        check("t2_hold_pc", bus.instr_pc, 32'h100);
        @(negedge clk);
        ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t2_seq0", pc_at(b), 32'h100);
        check("t2_seq1", pc_at(b + 1), 32'h104);
        check("t2_seq2", pc_at(b + 2), 32'h108);

        // 3: redirect with two reads in flight
        @(negedge clk);
        hold = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("t3_inflight", 32'(mq.size()), 32'd2);
        check("t3_req_full", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #3;
        check("t3_req_r", {31'b0, bus.imem_req}, 32'h0);
        b = lpc.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        hold = 1'b0;
        #3;
        k = 0;
        while (bus.imem_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("t3_req", {31'b0, bus.imem_req}, 32'h1);
        check("t3_addr", bus.imem_addr, 32'h200);
        repeat (8) @(negedge clk);
        check("t3_pc0", pc_at(b), 32'h200);
        check("t3_data0", dat_at(b), 32'h5A5A_0200);
        check("t3_pc1", pc_at(b + 1), 32'h204);

        // 4: bus error halts fetch until a redirect
        @(negedge clk);
        rst_n    = 1'b0;
        err_on   = 1'b1;
        err_addr = 32'h108;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b = lpc.size();
        repeat (14) @(negedge clk);
        #3;
        check("t4_pc1", pc_at(b + 1), 32'h104);
        check("t4_flt1", flt_at(b + 1), 32'h0);
        check("t4_pc", pc_at(b + 2), 32'h108);
        check("t4_data", dat_at(b + 2), 32'h0000_0013);
        check("t4_flt", flt_at(b + 2), 32'h1);
        check("t4_req", {31'b0, bus.imem_req}, 32'h0);
        hs0 = hs_cnt;
        repeat (6) @(negedge clk);
        #3;
        check("t4_nohs", 32'(hs_cnt - hs0), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        err_on         = 1'b0;
        #3;
        b = lpc.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_resume", pc_at(b), 32'h40);
        check("t4_rflt", flt_at(b), 32'h0);
        check("t4_next", pc_at(b + 1), 32'h44);

        // 5: redirect in the cycle a response returns
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mq.size() == 0 && k < 20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #3;
        check("t5_rvalid", {31'b0, bus.imem_rvalid}, 32'h1);
        check("t5_req_r", {31'b0, bus.imem_req}, 32'h0);
        b = lpc.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("t5_flushed", {31'b0, bus.instr_valid}, 32'h0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("t5_seq", pc_at(b + i), 32'h300 + 32'(4 * i));
        end

        // 6: reset with a full buffer
        @(negedge clk);
        ready = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("t6_full", {31'b0, bus.instr_valid}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        check("t6_req", {31'b0, bus.imem_req}, 32'h0);
        check("t6_addr", bus.imem_addr, 32'h100);
        check("t6_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("t6_data", bus.instr_data, 32'h0);
        check("t6_pc", bus.instr_pc, 32'h0);
        check("t6_fault", {31'b0, bus.instr_fault}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        b = lpc.size();
        #3;
        check("t6_req_rel", {31'b0, bus.imem_req}, 32'h1);
        check("t6_addr_rel", bus.imem_addr, 32'h100);
        repeat (6) @(negedge clk);
        check("t6_pc0", pc_at(b), 32'h100);

        // fetch_en low stops new requests
        @(negedge clk);
        fetch_en = 1'b0;
        repeat (4) @(negedge clk);
        hs0 = hs_cnt;
        repeat (4) @(negedge clk);
        #3;
        check("t7_req", {31'b0, bus.imem_req}, 32'h0);
        check("t7_nohs", 32'(hs_cnt - hs0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
